// File: rtl/cp0_exception_unit_if.sv
// Pipeline-to-CP0 bus: M-stage exception inputs, mfc0/mtc0/eret access,
// and the trap/redirect results fed back to the pipeline.
interface cp0_exception_unit_if;
  logic [4:0]  exc_code;
  logic [31:0] victim_pc;
  logic        victim_bd;
  logic [5:0]  hw_int;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic        eret_m;
  logic [31:0] cp0_rdata;
  logic        trap_req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  modport master (
    output exc_code, victim_pc, victim_bd, hw_int, cp0_addr, cp0_we, cp0_wdata, eret_m,
    input  cp0_rdata, trap_req, handler_pc, epc_out
  );

  modport slave (
    input  exc_code, victim_pc, victim_bd, hw_int, cp0_addr, cp0_we, cp0_wdata, eret_m,
    output cp0_rdata, trap_req, handler_pc, epc_out
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// Coprocessor 0 for the P7 MIPS pipeline: trap decision in the M stage,
// SR/Cause/EPC state, mfc0/mtc0 access and EPC for eret.
module cp0_exception_unit #(
  parameter logic [31:0] PRID_VALUE   = 32'h2021_0007,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic                    clk,
  input  logic                    reset_n,
  cp0_exception_unit_if.slave     bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_pend;
  logic        exc_pend;
  logic        trap;
  logic [31:0] victim_aligned;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] rdata;

  // EXL masks both sources so a handler cannot be re-entered before eret.
  assign int_pend = (|(bus.hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_pend = (bus.exc_code != 5'd0) & ~sr_exl;
  assign trap     = int_pend | exc_pend;

  assign victim_aligned = bus.victim_pc & ~32'd3;

  assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves rdata unassigned (no latch).
    rdata = '0;
    case (bus.cp0_addr)
      ADDR_SR:    rdata = sr_word;
      ADDR_CAUSE: rdata = cause_word;
      ADDR_EPC:   rdata = epc;
      ADDR_PRID:  rdata = PRID_VALUE;
      default:    rdata = '0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments; later statements in the block win, which orders mtc0 before eret.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= bus.hw_int;
      if (trap) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_pend ? 5'd0 : bus.exc_code;
        cause_bd  <= bus.victim_bd;
        epc       <= bus.victim_bd ? (victim_aligned - 32'd4) : victim_aligned;
      end else begin
        if (bus.cp0_we && bus.cp0_addr == ADDR_SR) begin
          sr_im  <= bus.cp0_wdata[15:10];
          sr_exl <= bus.cp0_wdata[1];
          sr_ie  <= bus.cp0_wdata[0];
        end
        if (bus.cp0_we && bus.cp0_addr == ADDR_EPC)
          epc <= bus.cp0_wdata;
        if (bus.eret_m)
          sr_exl <= 1'b0;
      end
    end
  end

  assign bus.cp0_rdata  = rdata;
  assign bus.trap_req   = trap;
  assign bus.handler_pc = HANDLER_ADDR;
  assign bus.epc_out    = epc;

endmodule
